// File: rtl/board_input_ctrl.sv
// Board input conditioner: synchronises and debounces the buttons and switches,
// and derives the CPU clock-enable from single-step presses or a free-run divider.
module board_input_ctrl #(
  parameter int N_SW       = 3,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20,
  parameter int DIV_W      = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_step_raw,
  input  logic            btn_mode_raw,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_stable,
  output logic            step_pulse,
  output logic            run_mode,
  output logic            cpu_ce,
  output logic [15:0]     ce_count
);

  // Bit 0 is the step button, bit 1 the mode button, the switches sit above.
  localparam int N_IN = N_SW + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N_IN-1:0]  raw;
  logic [N_IN-1:0]  s1;
  logic [N_IN-1:0]  s2;
  logic [N_IN-1:0]  stable;
  logic [N_IN-1:0]  stable_next;
  logic [CNT_W-1:0] cnt      [N_IN];
  logic [CNT_W-1:0] cnt_next [N_IN];
  logic             mode_pulse;
  logic [DIV_W-1:0] divider;

  assign raw       = {sw_raw, btn_mode_raw, btn_step_raw};
  assign sw_stable = stable[N_IN-1:2];

  always_comb begin
    // NOTE: defaults first so every path assigns every bit; otherwise latches are inferred.
    stable_next = stable;
    for (int i = 0; i < N_IN; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) stable_next[i] = s2[i];
        else                    cnt_next[i]    = cnt[i] + 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments everywhere below, so each register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      // NOTE: the counters are ordinary flops, not RAM, so clearing them all on reset is cheap and required.
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      stable <= stable_next;
      for (int i = 0; i < N_IN; i++) cnt[i] <= cnt_next[i];
    end
  end

  // Pulses line up with the first cycle the debounced level reads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_pulse <= 1'b0;
      mode_pulse <= 1'b0;
    end else begin
      step_pulse <= stable_next[0] & ~stable[0];
      mode_pulse <= stable_next[1] & ~stable[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_mode <= 1'b0;
      divider  <= '0;
      cpu_ce   <= 1'b0;
      ce_count <= '0;
    end else begin
      // cpu_ce uses run_mode as it was before any toggle on this edge.
      cpu_ce <= run_mode ? (divider == '1) : step_pulse;
      if (mode_pulse) begin
        run_mode <= ~run_mode;
        divider  <= '0;
      end else if (run_mode) begin
        divider <= divider + 1'b1;
      end
      if (cpu_ce) ce_count <= ce_count + 16'd1;
    end
  end

endmodule

// File: doc/board_input_ctrl.md
Name: board_input_ctrl

Overview:
Board-side input conditioner, the input counterpart of the seven-segment display path. It synchronises and debounces the raw push-buttons and slide switches. It also produces the CPU clock-enable, either as a single step per button press or as free-run at a divided rate. The debounced switches drive the display mux select, and cpu_ce gates the CPU so the core runs on the board clock.

Parameters:
N_SW, 3, number of slide switches (display select width)
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a change (10 ms at 100 MHz); minimum 2
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES
DIV_W, 20, free-run divider width; run-mode cpu_ce rate = clk / 2^DIV_W

Ports:
clk  in  1  board clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
btn_step_raw  in  1  raw step push-button, asynchronous, bouncy
btn_mode_raw  in  1  raw run/step mode push-button, asynchronous, bouncy
sw_raw  in  N_SW  raw slide switches, asynchronous, bouncy
sw_stable  out  N_SW  debounced switch levels
step_pulse  out  1  one-cycle pulse per debounced step-button press
run_mode  out  1  0 = single-step mode, 1 = free-run mode
cpu_ce  out  1  one-cycle CPU clock-enable pulse
ce_count  out  16  count of cpu_ce pulses, for the display

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous, active-high, and the only reset.
- Reset values: all sync flops, stable levels, debounce counters, divider, run_mode, step_pulse, cpu_ce and ce_count are 0.
- Reset asserted mid-debounce or mid-divide discards all progress. No pulse is produced on the cycle rst deasserts.
- Synchroniser: each raw input (2 buttons + N_SW switches) passes through a 2-flop chain (s1 then s2). Debounce logic sees only s2.
- Debounce, per input, independent counter:
  - If s2 == stable: counter <= 0.
  - Else if counter == DEB_CYCLES-1: stable <= s2 and counter <= 0.
  - Else: counter <= counter+1.
  - Any bounce back to the stable value before acceptance clears the counter.
  - Latency: raw level captured at edge k is accepted into stable at edge k+1+DEB_CYCLES.
- Edge detect: step_pulse and mode_pulse (internal) are registered.
  - Each is high for exactly the one cycle in which the corresponding stable button first reads 1.
  - Release (1->0) produces no pulse. A held button gives one pulse only.
- Mode: mode_pulse toggles run_mode on the following edge. The same edge clears the divider to 0.
- cpu_ce, registered, evaluated with the current run_mode (the value before any toggle on that edge):
  - Step mode: cpu_ce on the next cycle = step_pulse. One press gives exactly one cpu_ce.
  - Run mode: divider increments every cycle and wraps from all-ones to 0. cpu_ce is asserted for the one cycle after divider == all-ones, i.e. every 2^DIV_W cycles. step_pulse is ignored.
- Simultaneous step_pulse and mode_pulse while in step mode: cpu_ce still fires once, and the mode then toggles.
- ce_count increments by 1 on every cycle cpu_ce is high. It wraps from 16'hFFFF to 0.
- sw_stable is the debounced switch vector, used directly as the display select. No pulses are generated for switches.

Test Plan:
Use DEB_CYCLES=4 and DIV_W=3 for all scenarios.
1. Reset: hold rst 3 cycles with all raw inputs = 1 -> all outputs 0 during rst. First sw_stable=3'b111 appears 5 cycles after rst deasserts, with no step_pulse on the release edge.
2. Bounce rejection: toggle btn_step_raw 1,0,1,0 each cycle, then hold 1 -> exactly one step_pulse, 5 edges after the final 0->1 capture. cpu_ce follows 1 cycle later. ce_count = 1.
3. Hold/release: hold btn_step_raw=1 for 50 cycles, then 0 for 20 -> one step_pulse, one cpu_ce, no pulse on release.
4. Free-run: one press of btn_mode_raw -> run_mode=1, then cpu_ce every 8 cycles. After 64 cycles ce_count has advanced by 8. Step presses in this mode leave ce_count unchanged.
5. Simultaneous presses: in step mode, raise btn_step_raw and btn_mode_raw on the same edge -> one cpu_ce. run_mode=1 after. Divider restarts, so the first run-mode cpu_ce arrives 8 cycles after the toggle.
6. Wrap and reset-mid-debounce:
   - Preload ce_count to 16'hFFFF via step presses (or a force) and press step -> ce_count = 0.
   - Assert rst while a switch counter is at 2 -> sw_stable stays at its reset value, and the change needs a full 4-cycle debounce after release.
